// File: rtl/percept_node.sv
// Serial-bus perceptron slave: deframes bytes, decodes commands, stores weights/inputs, runs MAC on EVAL.
// Optional build macro PERCEPT_SAT_EN saturates the activation byte instead of wrapping it.
module percept_node #(
    parameter logic [2:0]         ADDR   = 3'd0,
    parameter int unsigned        N_IN   = 8,
    parameter logic signed [18:0] THRESH = 19'sd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial,
    output logic       busy,
    output logic       valid,
    output logic       fire,
    output logic [7:0] act,
    output logic       drop,
    output logic       ferr
);

    localparam int unsigned ACC_W  = 19;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned MEM_D  = 8;

    typedef enum logic [1:0] {RX_WAIT_IDLE, RX_IDLE, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {DEC_HDR, DEC_PAYLOAD} dec_state_t;

    rx_state_t  rx_state, rx_state_nxt;
    dec_state_t dec_state, dec_state_nxt;

    logic [2:0] rx_cnt;
    logic [7:0] rx_byte;
    logic       byte_acc_c;
    logic       frame_err_c;

    logic [2:0] hdr_addr;
    logic       hdr_is_x;
    logic [2:0] hdr_idx;

    logic [7:0] w_mem [MEM_D];
    logic [7:0] x_mem [MEM_D];

    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod_c;
    logic [CNT_W-1:0]         mac_cnt;
    logic [7:0]               act_c;

    logic hdr_match_c, eval_cmd_c, clear_cmd_c, load_match_c, load_bad_c;
    logic start_eval_c, do_clear_c, wr_c, drop_c;

    // Receiver state register and bit shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_WAIT_IDLE;
            rx_cnt   <= '0;
            rx_byte  <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= 3'd7;
            end else if (rx_state == RX_DATA) begin
                rx_byte[rx_cnt] <= serial;
                rx_cnt          <= rx_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        byte_acc_c   = 1'b0;
        frame_err_c  = 1'b0;
        case (rx_state)
            RX_WAIT_IDLE: if (serial) rx_state_nxt = RX_IDLE;
            RX_IDLE:      if (!serial) rx_state_nxt = RX_DATA;
            RX_DATA:      if (rx_cnt == 3'd0) rx_state_nxt = RX_STOP;
            RX_STOP: begin
                if (serial) begin
                    byte_acc_c   = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end else begin
                    frame_err_c  = 1'b1;
                    rx_state_nxt = RX_WAIT_IDLE;
                end
            end
            default: rx_state_nxt = RX_WAIT_IDLE;
        endcase
    end

    // Decoder: every node walks header/payload so all nodes stay aligned on the shared line
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_state <= DEC_HDR;
            hdr_addr  <= '0;
            hdr_is_x  <= 1'b0;
            hdr_idx   <= '0;
        end else begin
            dec_state <= dec_state_nxt;
            if (dec_state == DEC_HDR && byte_acc_c) begin
                hdr_addr <= rx_byte[7:5];
                hdr_is_x <= rx_byte[3];
                hdr_idx  <= rx_byte[2:0];
            end
        end
    end

    always_comb begin
        dec_state_nxt = dec_state;
        if (frame_err_c) begin
            dec_state_nxt = DEC_HDR;
        end else if (byte_acc_c) begin
            if (dec_state == DEC_HDR) begin
                if (!rx_byte[4]) dec_state_nxt = DEC_PAYLOAD;
            end else begin
                dec_state_nxt = DEC_HDR;
            end
        end
    end

    always_comb begin
        hdr_match_c  = (dec_state == DEC_HDR) && byte_acc_c && (rx_byte[7:5] == ADDR);
        eval_cmd_c   = hdr_match_c && (rx_byte[4:3] == 2'b10);
        clear_cmd_c  = hdr_match_c && (rx_byte[4:3] == 2'b11);
        load_match_c = (dec_state == DEC_PAYLOAD) && byte_acc_c && (hdr_addr == ADDR);
        load_bad_c   = load_match_c && (busy || (32'(hdr_idx) >= N_IN));
        start_eval_c = eval_cmd_c && !busy;
        do_clear_c   = clear_cmd_c && !busy;
        wr_c         = load_match_c && !load_bad_c;
        drop_c       = ((eval_cmd_c || clear_cmd_c) && busy) || load_bad_c;
    end

    // Weight/input storage
    always_ff @(posedge clk) begin
        if (rst || do_clear_c) begin
            for (int i = 0; i < MEM_D; i++) begin
                w_mem[i] <= '0;
                x_mem[i] <= '0;
            end
        end else if (wr_c) begin
            if (hdr_is_x) x_mem[hdr_idx] <= rx_byte;
            else          w_mem[hdr_idx] <= rx_byte;
        end
    end

    always_comb begin
        prod_c = $signed(w_mem[mac_cnt[2:0]]) * $signed(x_mem[mac_cnt[2:0]]);
    end

`ifdef PERCEPT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = 19'sd127;
    localparam logic signed [ACC_W-1:0] SAT_LO = -19'sd128;
    always_comb begin
        if (acc > SAT_HI)      act_c = 8'h7F;
        else if (acc < SAT_LO) act_c = 8'h80;
        else                   act_c = acc[7:0];
    end
`else
    always_comb begin
        act_c = acc[7:0];
    end
`endif

    // MAC sequencer: one product per cycle, result registered once the last term is in
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            valid   <= 1'b0;
            fire    <= 1'b0;
            act     <= '0;
            drop    <= 1'b0;
            ferr    <= 1'b0;
            acc     <= '0;
            mac_cnt <= '0;
        end else begin
            valid <= 1'b0;
            drop  <= drop_c;
            ferr  <= frame_err_c;
            if (start_eval_c) begin
                busy    <= 1'b1;
                acc     <= '0;
                mac_cnt <= '0;
            end else if (busy) begin
                if (mac_cnt == CNT_W'(N_IN)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    fire  <= (acc > THRESH);
                    act   <= act_c;
                end else begin
                    acc     <= acc + ACC_W'(prod_c);
                    mac_cnt <= mac_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_percept_node.sv
// Bench for percept_node: byte-level reference model driven from frame-sender events, compared every cycle.
module tb_percept_node;

    localparam int M_ADDR = 0;
    localparam int M_N    = 4;
    localparam int M_TH   = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial = 1'b1;
    logic       busy, valid, fire, drop, ferr;
    logic [7:0] act;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // events announced by the frame sender for the edge that samples the stop bit
    logic       ev_acc = 1'b0;
    logic       ev_ferr = 1'b0;
    logic [7:0] ev_byte = '0;

    // reference model state
    int   mw [8];
    int   mx [8];
    bit   m_payload;
    int   m_saddr, m_sisx, m_sidx;
    int   eval_left;
    int   m_res;
    logic m_busy, m_valid, m_fire, m_drop, m_ferr;
    logic [7:0] m_act;

    percept_node #(.ADDR(3'(M_ADDR)), .N_IN(M_N), .THRESH(19'sd0)) dut (
        .clk(clk), .rst(rst), .serial(serial), .busy(busy), .valid(valid),
        .fire(fire), .act(act), .drop(drop), .ferr(ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic [7:0] act_of(input int r);
        int c;
        logic [31:0] rv;
`ifdef PERCEPT_SAT_EN
        c = (r > 127) ? 127 : ((r < -128) ? -128 : r);
`else
        c = r;
`endif
        rv = c;
        return rv[7:0];
    endfunction

    // Reference model: command semantics applied per accepted byte
    always @(posedge clk) begin
        logic bprev;
        int   a, op, idx, sum;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin mw[i] = 0; mx[i] = 0; end
            m_payload = 0; eval_left = 0; m_res = 0;
            m_busy = 0; m_valid = 0; m_fire = 0; m_act = 0; m_drop = 0; m_ferr = 0;
            m_saddr = 0; m_sisx = 0; m_sidx = 0;
        end else begin
            bprev   = m_busy;
            m_valid = 0; m_drop = 0; m_ferr = 0;
            if (eval_left > 0) begin
                eval_left--;
                if (eval_left == 0) begin
                    m_busy  = 0;
                    m_valid = 1;
                    m_fire  = (m_res > M_TH);
                    m_act   = act_of(m_res);
                end
            end
            if (ev_ferr) begin
                m_ferr    = 1;
                m_payload = 0;
            end else if (ev_acc) begin
                a = int'(ev_byte[7:5]); op = int'(ev_byte[4:3]); idx = int'(ev_byte[2:0]);
                if (!m_payload) begin
                    if (op < 2) begin
                        m_payload = 1; m_saddr = a; m_sisx = op; m_sidx = idx;
                    end else if (a == M_ADDR) begin
                        if (bprev) m_drop = 1;
                        else if (op == 2) begin
                            sum = 0;
                            for (int i = 0; i < M_N; i++) sum += mw[i] * mx[i];
                            m_res = sum; eval_left = M_N + 1; m_busy = 1;
                        end else begin
                            for (int i = 0; i < 8; i++) begin mw[i] = 0; mx[i] = 0; end
                        end
                    end
                end else begin
                    m_payload = 0;
                    if (m_saddr == M_ADDR) begin
                        if (bprev || m_sidx >= M_N) m_drop = 1;
                        else if (m_sisx == 1) mx[m_sidx] = $signed(ev_byte);
                        else mw[m_sidx] = $signed(ev_byte);
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", int'(busy), int'(m_busy));
            chk("valid", int'(valid), int'(m_valid));
            chk("fire", int'(fire), int'(m_fire));
            chk("act", int'(act), int'(m_act));
            chk("drop", int'(drop), int'(m_drop));
            chk("ferr", int'(ferr), int'(m_ferr));
        end
    end

    task automatic send_bit(input logic b);
        serial = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic good, input int gap);
        for (int i = 0; i < gap; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ev_byte = b; ev_acc = good; ev_ferr = !good;
        send_bit(good);
        ev_acc = 1'b0; ev_ferr = 1'b0;
        serial = 1'b1;
    endtask

    task automatic wait_valid(output int k);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k, vc;
        logic [7:0] b;
        logic good, prev_bad;
        int gap;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_act", int'(act), 0);

        // weights 1..4, inputs 1, evaluate
        for (int i = 0; i < 4; i++) send_frame(8'(i), 1'b1, 1);
        for (int i = 0; i < 4; i++) send_frame(8'(i + 1), 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            send_frame(8'(8 + i), 1'b1, 0);
            send_frame(8'h01, 1'b1, 0);
        end
        send_frame(8'h10, 1'b1, 0);
        wait_valid(k);
        chk("t1_latency", k, 5);
        chk("t1_fire", int'(fire), 1);
        chk("t1_act", int'(act), 8'h0A);

        // load to another address is ignored
        send_frame(8'h60, 1'b1, 1);
        send_frame(8'h7F, 1'b1, 0);
        send_frame(8'h10, 1'b1, 0);
        wait_valid(k);
        chk("t2_act", int'(act), 8'h0A);

        // clear then 127*127
        send_frame(8'h18, 1'b1, 1);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'h7F, 1'b1, 0);
        send_frame(8'h08, 1'b1, 0);
        send_frame(8'h7F, 1'b1, 0);
        send_frame(8'h10, 1'b1, 0);
        wait_valid(k);
        chk("t3_fire", int'(fire), 1);
`ifdef PERCEPT_SAT_EN
        chk("t3_act", int'(act), 8'h7F);
`else
        chk("t3_act", int'(act), 8'h01);
`endif

        // framing error, then normal loads resume
        send_frame(8'h00, 1'b0, 1);
        chk("t4_ferr", int'(ferr), 1);
        send_frame(8'h01, 1'b1, 1);
        send_frame(8'h05, 1'b1, 0);
        send_frame(8'h09, 1'b1, 0);
        send_frame(8'h02, 1'b1, 0);
        send_frame(8'h10, 1'b1, 0);
        wait_valid(k);
`ifdef PERCEPT_SAT_EN
        chk("t4_act", int'(act), 8'h7F);
`else
        chk("t4_act", int'(act), 8'h0B);
`endif

        // load right behind EVAL, then an out-of-range index
        send_frame(8'h10, 1'b1, 1);
        send_frame(8'h01, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        send_frame(8'h05, 1'b1, 1);
        send_frame(8'h33, 1'b1, 0);
        chk("t5_drop_idx", int'(drop), 1);

        // clear then evaluate zero; then reset mid-evaluation
        send_frame(8'h18, 1'b1, 1);
        send_frame(8'h10, 1'b1, 0);
        wait_valid(k);
        chk("t6_fire", int'(fire), 0);
        chk("t6_act", int'(act), 0);
        send_frame(8'h10, 1'b1, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_busy_rst", int'(busy), 0);
        vc = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (valid) vc++;
        end
        chk("t6_novalid", vc, 0);

        // randomized traffic, occasional framing errors and foreign addresses
        prev_bad = 1'b1;
        for (int n = 0; n < 400; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) b[7:5] = 3'(M_ADDR);
            good = ($urandom_range(0, 24) != 0);
            gap  = prev_bad ? 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 2));
            send_frame(b, good, gap);
            prev_bad = !good;
        end
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
